// File: rtl/display_dwell_buf_pkg.sv
// Shared types and constants for the display dwell buffer.
package display_dwell_buf_pkg;

    // Board clock; the default dwell holds each word for one second.
    localparam int unsigned BOARD_CLK_HZ         = 50_000_000;
    localparam int unsigned DEFAULT_DWELL_CYCLES = BOARD_CLK_HZ;

    // Dwell state machine: IDLE means the timer has expired, HOLD means it is counting.
    typedef enum logic {
        StIdle = 1'b0,
        StHold = 1'b1
    } dwell_state_e;

    // Counter width for a down-counter loaded with n-1; never narrower than one bit.
    function automatic int unsigned timer_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/display_dwell_buf_if.sv
// Valid/ready write port from the CPU into the dwell buffer.
interface display_dwell_buf_if #(
    parameter int unsigned WIDTH = 16
) ();

    logic [WIDTH-1:0] wr_data;
    logic             wr_valid;
    logic             wr_ready;

    modport master (output wr_data, output wr_valid, input wr_ready);
    modport slave  (input wr_data, input wr_valid, output wr_ready);

endinterface

// File: rtl/display_dwell_buf_sync_fifo.sv
// Synchronous first-word-fall-through FIFO; full/empty derive from the level count.
module sync_fifo
    import display_dwell_buf_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           wdata_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic [$clog2(DEPTH+1)-1:0] level_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int unsigned PtrW = timer_width(DEPTH);
    localparam int unsigned LvlW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LvlW-1:0]  level_q, level_d;

    // Next-state for storage, pointers and level; pointers wrap naturally (DEPTH is 2^n).
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_i) begin
            mem_d[wr_ptr_q] = wdata_i;
            wr_ptr_d        = wr_ptr_q + PtrW'(1);
        end
        if (pop_i) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        unique case ({push_i, pop_i})
            2'b10:   level_d = level_q + LvlW'(1);
            2'b01:   level_d = level_q - LvlW'(1);
            default: level_d = level_q;
        endcase
    end

    // Control state; reset empties the queue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset: stale entries are unreachable once level is zero.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign level_o = level_q;
    assign full_o  = (level_q == LvlW'(DEPTH));
    assign empty_o = (level_q == '0);

endmodule

// File: rtl/display_dwell_buf.sv
// Holds each queued CPU word on the hex display for at least DWELL_CYCLES clocks.
module display_dwell_buf
    import display_dwell_buf_pkg::*;
#(
    parameter int unsigned WIDTH        = 16,
    parameter int unsigned DEPTH        = 8,
    parameter int unsigned DWELL_CYCLES = DEFAULT_DWELL_CYCLES
) (
    input  logic                       clk,
    input  logic                       rst,
    display_dwell_buf_if.slave         wr,
    output logic [WIDTH-1:0]           data_out,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       busy
);

    localparam int unsigned       TimerW    = timer_width(DWELL_CYCLES);
    localparam int unsigned       LvlW      = $clog2(DEPTH + 1);
    localparam logic [TimerW-1:0] TimerLoad = TimerW'(DWELL_CYCLES - 1);

    dwell_state_e      state_q, state_d;
    logic [TimerW-1:0] timer_q, timer_d;
    logic [WIDTH-1:0]  data_q, data_d;

    logic              push;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [WIDTH-1:0]  fifo_head;
    logic [LvlW-1:0]   fifo_level;

    // Ready depends only on registered level, never on wr_valid.
    assign wr.wr_ready = !fifo_full;
    assign push        = wr.wr_valid && !fifo_full;

    sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .wdata_i (wr.wr_data),
        .pop_i   (pop),
        .rdata_o (fifo_head),
        .level_o (fifo_level),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Dwell FSM: pop when idle or when the hold timer has run out, else count down.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        data_d  = data_q;
        pop     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    data_d  = fifo_head;
                    timer_d = TimerLoad;
                    state_d = StHold;
                end
            end
            StHold: begin
                if (timer_q != '0) begin
                    timer_d = timer_q - TimerW'(1);
                end else if (!fifo_empty) begin
                    pop     = 1'b1;
                    data_d  = fifo_head;
                    timer_d = TimerLoad;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM state, dwell timer and the displayed word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            timer_q <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            data_q  <= data_d;
        end
    end

    assign data_out = data_q;
    assign level    = fifo_level;
    assign busy     = (state_q == StHold) || (fifo_level != '0);

endmodule
